// File: rtl/blk_mem_gen_v8_2_softecc_input_reg_stage.sv
// Port-A soft-ECC write stage: SECDED-encodes DINA, applies armed single/double-bit error injection.
// Define SOFTECC_INJ_COUNT_EN to build the saturating injected-error counters.
module blk_mem_gen_v8_2_softecc_input_reg_stage #(
    parameter int C_DATA_WIDTH               = 32,
    parameter int C_ADDRA_WIDTH              = 10,
    parameter int C_HAS_SOFTECC_INPUT_REGS_A = 0,
    parameter int FLOP_DELAY                 = 100,
    localparam int C_ECC_WIDTH = ((C_DATA_WIDTH <= 1)  ? 2 :
                                  (C_DATA_WIDTH <= 4)  ? 3 :
                                  (C_DATA_WIDTH <= 11) ? 4 :
                                  (C_DATA_WIDTH <= 26) ? 5 :
                                  (C_DATA_WIDTH <= 57) ? 6 : 7) + 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     WEA,
    input  logic [C_ADDRA_WIDTH-1:0] ADDRA,
    input  logic [C_DATA_WIDTH-1:0]  DINA,
    input  logic                     INJECTSBITERR,
    input  logic                     INJECTDBITERR,
    output logic                     WEA_OUT,
    output logic [C_ADDRA_WIDTH-1:0] ADDRA_OUT,
    output logic [C_DATA_WIDTH-1:0]  DINA_OUT,
    output logic [C_ECC_WIDTH-1:0]   ECCA_OUT,
    output logic                     SBITERR_INJ,
    output logic                     DBITERR_INJ,
    output logic                     INJ_ARMED,
    output logic [15:0]              SBIT_INJ_CNT,
    output logic [15:0]              DBIT_INJ_CNT
);

    localparam int ECC_R = C_ECC_WIDTH - 1;

    // A 1-bit data word has no second data bit, so double-bit injection also hits check bit 0.
    localparam logic [C_DATA_WIDTH-1:0] DMASK_S = C_DATA_WIDTH'(1);
    localparam logic [C_DATA_WIDTH-1:0] DMASK_D = C_DATA_WIDTH'((C_DATA_WIDTH == 1) ? 1 : 3);
    localparam logic [C_ECC_WIDTH-1:0]  EMASK_D = C_ECC_WIDTH'((C_DATA_WIDTH == 1) ? 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM_S = 2'd1,
        S_ARM_D = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ECC_R-1:0]        w_syn;
    logic [C_ECC_WIDTH-1:0]  w_ecc_clean;
    logic [C_ECC_WIDTH-1:0]  w_ecc_inj;
    logic [C_DATA_WIDTH-1:0] w_din_inj;
    logic                    w_kind_s;
    logic                    w_kind_d;
    logic                    w_apply_s;
    logic                    w_apply_d;
    logic                    w_unused_flop_delay;

    // FLOP_DELAY only exists for drop-in compatibility with the vendor model.
    assign w_unused_flop_delay = (FLOP_DELAY != 0);

    // Data bit k sits at the k-th codeword position that is not a power of two.
    function automatic logic [C_DATA_WIDTH-1:0] parity_mask(input int bit_i);
        logic [C_DATA_WIDTH-1:0] m;
        int p;
        m = '0;
        p = 2;
        for (int k = 0; k < C_DATA_WIDTH; k++) begin
            p = p + 1;
            if ((p & (p - 1)) == 0) p = p + 1;
            m[k] = ((p >> bit_i) & 1) != 0;
        end
        return m;
    endfunction

    always_comb begin
        w_syn = '0;
        for (int i = 0; i < ECC_R; i++) begin
            w_syn[i] = ^(DINA & parity_mask(i));
        end
    end

    assign w_ecc_clean = {(^DINA) ^ (^w_syn), w_syn};

    assign w_kind_d  = (r_state == S_ARM_D) || INJECTDBITERR;
    assign w_kind_s  = !w_kind_d && ((r_state == S_ARM_S) || INJECTSBITERR);
    assign w_apply_d = WEA && !RST && w_kind_d;
    assign w_apply_s = WEA && !RST && w_kind_s;

    always_comb begin
        w_din_inj = DINA;
        w_ecc_inj = w_ecc_clean;
        if (w_apply_d) begin
            w_din_inj = DINA ^ DMASK_D;
            w_ecc_inj = w_ecc_clean ^ EMASK_D;
        end else if (w_apply_s) begin
            w_din_inj = DINA ^ DMASK_S;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (WEA) begin
            w_state_nxt = S_IDLE;
        end else if (w_kind_d) begin
            w_state_nxt = S_ARM_D;
        end else if (w_kind_s) begin
            w_state_nxt = S_ARM_S;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign INJ_ARMED = (r_state != S_IDLE);

    generate
        if (C_HAS_SOFTECC_INPUT_REGS_A != 0) begin : g_regs
            logic                     r_wea_p1;
            logic [C_ADDRA_WIDTH-1:0] r_addr_p1;
            logic [C_DATA_WIDTH-1:0]  r_din_p1;
            logic [C_ECC_WIDTH-1:0]   r_ecc_p1;
            logic                     r_sinj_p1;
            logic                     r_dinj_p1;

            // Single register stage towards the RAM; one write accepted every cycle.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_wea_p1  <= 1'b0;
                    r_addr_p1 <= '0;
                    r_din_p1  <= '0;
                    r_ecc_p1  <= '0;
                    r_sinj_p1 <= 1'b0;
                    r_dinj_p1 <= 1'b0;
                end else begin
                    r_wea_p1  <= WEA;
                    r_addr_p1 <= ADDRA;
                    r_din_p1  <= w_din_inj;
                    r_ecc_p1  <= w_ecc_inj;
                    r_sinj_p1 <= w_apply_s;
                    r_dinj_p1 <= w_apply_d;
                end
            end

            assign WEA_OUT     = r_wea_p1;
            assign ADDRA_OUT   = r_addr_p1;
            assign DINA_OUT    = r_din_p1;
            assign ECCA_OUT    = r_ecc_p1;
            assign SBITERR_INJ = r_sinj_p1;
            assign DBITERR_INJ = r_dinj_p1;
        end else begin : g_comb
            // Reset suppresses the write and any injection even on the unregistered path.
            assign WEA_OUT     = WEA && !RST;
            assign ADDRA_OUT   = ADDRA;
            assign DINA_OUT    = w_din_inj;
            assign ECCA_OUT    = w_ecc_inj;
            assign SBITERR_INJ = w_apply_s;
            assign DBITERR_INJ = w_apply_d;
        end
    endgenerate

`ifdef SOFTECC_INJ_COUNT_EN
    logic [15:0] r_sbit_cnt;
    logic [15:0] r_dbit_cnt;

    // Counted when the injected write is accepted, saturating at all-ones.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sbit_cnt <= 16'h0000;
            r_dbit_cnt <= 16'h0000;
        end else begin
            if (w_apply_s && (r_sbit_cnt != 16'hFFFF)) r_sbit_cnt <= r_sbit_cnt + 16'd1;
            if (w_apply_d && (r_dbit_cnt != 16'hFFFF)) r_dbit_cnt <= r_dbit_cnt + 16'd1;
        end
    end

    assign SBIT_INJ_CNT = r_sbit_cnt;
    assign DBIT_INJ_CNT = r_dbit_cnt;
`else
    assign SBIT_INJ_CNT = 16'h0000;
    assign DBIT_INJ_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_blk_mem_gen_v8_2_softecc_input_reg_stage.sv
// Bench for the port-A soft-ECC stage: one unregistered and one registered instance on shared stimulus.
module tb_blk_mem_gen_v8_2_softecc_input_reg_stage;

    logic        clk;
    logic        rst;
    logic        wea;
    logic [9:0]  addra;
    logic [31:0] dina;
    logic        inj_s;
    logic        inj_d;

    logic        o0_wea, o1_wea;
    logic [9:0]  o0_addr, o1_addr;
    logic [31:0] o0_din, o1_din;
    logic [6:0]  o0_ecc, o1_ecc;
    logic        o0_sinj, o1_sinj, o0_dinj, o1_dinj, o0_arm, o1_arm;
    logic [15:0] o0_scnt, o1_scnt, o0_dcnt, o1_dcnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        wea;
        logic [9:0]  addr;
        logic [31:0] din;
        logic [6:0]  ecc;
        logic        s;
        logic        d;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int          m_state = 0;
    logic [15:0] m_cnt_s = 16'h0;
    logic [15:0] m_cnt_d = 16'h0;

    blk_mem_gen_v8_2_softecc_input_reg_stage #(
        .C_DATA_WIDTH(32), .C_ADDRA_WIDTH(10), .C_HAS_SOFTECC_INPUT_REGS_A(0), .FLOP_DELAY(100)
    ) dut0 (
        .CLK(clk), .RST(rst), .WEA(wea), .ADDRA(addra), .DINA(dina),
        .INJECTSBITERR(inj_s), .INJECTDBITERR(inj_d),
        .WEA_OUT(o0_wea), .ADDRA_OUT(o0_addr), .DINA_OUT(o0_din), .ECCA_OUT(o0_ecc),
        .SBITERR_INJ(o0_sinj), .DBITERR_INJ(o0_dinj), .INJ_ARMED(o0_arm),
        .SBIT_INJ_CNT(o0_scnt), .DBIT_INJ_CNT(o0_dcnt)
    );

    blk_mem_gen_v8_2_softecc_input_reg_stage #(
        .C_DATA_WIDTH(32), .C_ADDRA_WIDTH(10), .C_HAS_SOFTECC_INPUT_REGS_A(1), .FLOP_DELAY(100)
    ) dut1 (
        .CLK(clk), .RST(rst), .WEA(wea), .ADDRA(addra), .DINA(dina),
        .INJECTSBITERR(inj_s), .INJECTDBITERR(inj_d),
        .WEA_OUT(o1_wea), .ADDRA_OUT(o1_addr), .DINA_OUT(o1_din), .ECCA_OUT(o1_ecc),
        .SBITERR_INJ(o1_sinj), .DBITERR_INJ(o1_dinj), .INJ_ARMED(o1_arm),
        .SBIT_INJ_CNT(o1_scnt), .DBIT_INJ_CNT(o1_dcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Hamming positions 1..38; data fills the non-power-of-two slots in order.
    function automatic logic [6:0] ref_ecc(input logic [31:0] d);
        logic [5:0] syn;
        int k;
        syn = '0;
        k = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (d[k]) syn = syn ^ 6'(p);
                k++;
            end
        end
        return {(^d) ^ (^syn), syn};
    endfunction

    function automatic logic [15:0] exp_cnt(input logic [15:0] c);
`ifdef SOFTECC_INJ_COUNT_EN
        return c;
`else
        return 16'h0000 & c;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic we, input logic [9:0] a, input logic [31:0] din,
                        input logic s, input logic d, input logic r);
        exp_t        e0, e1, eo;
        logic        kd, ks, ad, as;
        logic        arm_e;
        logic [15:0] cs_e, cd_e;
        @(posedge clk);
        #1;
        rst = r; wea = we; addra = a; dina = din; inj_s = s; inj_d = d;

        kd = (m_state == 2) || d;
        ks = !kd && ((m_state == 1) || s);
        ad = we && !r && kd;
        as = we && !r && ks;
        e0.wea  = we && !r;
        e0.addr = a;
        e0.din  = din ^ (ad ? 32'h3 : (as ? 32'h1 : 32'h0));
        e0.ecc  = ref_ecc(din);
        e0.s    = as;
        e0.d    = ad;
        e1      = r ? '0 : e0;
        q0.push_back(e0);
        q1.push_back(e1);
        arm_e = (m_state != 0);
        cs_e  = exp_cnt(m_cnt_s);
        cd_e  = exp_cnt(m_cnt_d);

        if (r) begin
            m_state = 0; m_cnt_s = 16'h0; m_cnt_d = 16'h0;
        end else begin
            if (we)      m_state = 0;
            else if (kd) m_state = 2;
            else if (ks) m_state = 1;
            if (as && m_cnt_s != 16'hFFFF) m_cnt_s = m_cnt_s + 16'd1;
            if (ad && m_cnt_d != 16'hFFFF) m_cnt_d = m_cnt_d + 16'd1;
        end

        @(negedge clk);
        eo = q0.pop_front();
        chk("c_wea",  o0_wea,  eo.wea);
        chk("c_addr", o0_addr, eo.addr);
        chk("c_din",  o0_din,  eo.din);
        chk("c_ecc",  o0_ecc,  eo.ecc);
        chk("c_sinj", o0_sinj, eo.s);
        chk("c_dinj", o0_dinj, eo.d);
        if (q1.size() > 1) begin
            eo = q1.pop_front();
            chk("r_wea",  o1_wea,  eo.wea);
            chk("r_addr", o1_addr, eo.addr);
            chk("r_din",  o1_din,  eo.din);
            chk("r_ecc",  o1_ecc,  eo.ecc);
            chk("r_sinj", o1_sinj, eo.s);
            chk("r_dinj", o1_dinj, eo.d);
        end
        chk("armed0", o0_arm,  arm_e);
        chk("armed1", o1_arm,  arm_e);
        chk("scnt0",  o0_scnt, cs_e);
        chk("scnt1",  o1_scnt, cs_e);
        chk("dcnt0",  o0_dcnt, cd_e);
        chk("dcnt1",  o1_dcnt, cd_e);
    endtask

    initial begin
        rst = 1'b1; wea = 1'b0; addra = '0; dina = '0; inj_s = 1'b0; inj_d = 1'b0;

        // Reset, including a write and both requests that reset must override.
        step(0, 10'd0, 32'h0, 0, 0, 1);
        step(1, 10'd3, 32'h1234_5678, 1, 1, 1);

        // Plain encodes.
        step(1, 10'd5, 32'h0000_0000, 0, 0, 0);
        chk("spec_ecc0", o0_ecc, 7'h00);
        step(1, 10'd6, 32'h0000_0001, 0, 0, 0);
        step(0, 10'd0, 32'h0, 0, 0, 0);
        chk("spec_ecc1_reg", o1_ecc, 7'h43);
        chk("spec_din1_reg", o1_din, 32'h1);
        step(1, 10'h3FF, 32'hDEAD_BEEF, 0, 0, 0);
        step(1, 10'h155, 32'hFFFF_FFFF, 0, 0, 0);
        step(1, 10'h2AA, 32'h8000_0000, 0, 0, 0);

        // Armed single-bit, then applied to the next write.
        step(0, 10'd0, 32'h0, 1, 0, 0);
        step(0, 10'd0, 32'h0, 0, 0, 0);
        step(1, 10'd7, 32'h0, 0, 0, 0);
        chk("spec_sinj_din", o0_din, 32'h1);

        // Single then double arms: upgrade to double.
        step(0, 10'd0, 32'h0, 1, 0, 0);
        step(0, 10'd0, 32'h0, 0, 1, 0);
        step(1, 10'd8, 32'h0, 0, 0, 0);
        chk("spec_dinj_din", o0_din, 32'h3);

        // Same-cycle request with a write, and both requests at once.
        step(1, 10'd9, 32'hA5A5_A5A5, 1, 0, 0);
        step(1, 10'd10, 32'h5A5A_5A5A, 1, 1, 0);
        step(0, 10'd0, 32'h0, 1, 1, 0);
        step(1, 10'd11, 32'h0F0F_0F0F, 0, 0, 0);

        // ARM_D is not downgraded by a later single-bit request.
        step(0, 10'd0, 32'h0, 0, 1, 0);
        step(0, 10'd0, 32'h0, 1, 0, 0);
        step(1, 10'd12, 32'hFFFF_0000, 1, 0, 0);

        // Armed injection is dropped by reset.
        step(0, 10'd0, 32'h0, 0, 1, 0);
        step(0, 10'd0, 32'h0, 0, 0, 1);
        step(1, 10'd13, 32'h0, 0, 0, 0);
        chk("rst_drop_din", o0_din, 32'h0);

        // Counter saturation.
`ifdef SOFTECC_INJ_COUNT_EN
        force dut0.r_sbit_cnt = 16'hFFFE;
        force dut1.r_sbit_cnt = 16'hFFFE;
        #1;
        release dut0.r_sbit_cnt;
        release dut1.r_sbit_cnt;
        m_cnt_s = 16'hFFFE;
`endif
        step(1, 10'd20, 32'h1111_1111, 1, 0, 0);
        step(1, 10'd21, 32'h2222_2222, 1, 0, 0);
        step(1, 10'd22, 32'h3333_3333, 1, 0, 0);
        step(0, 10'd0, 32'h0, 0, 0, 0);
`ifdef SOFTECC_INJ_COUNT_EN
        chk("sat_cnt", o0_scnt, 16'hFFFF);
`else
        chk("cnt_off", o0_scnt, 16'h0000);
`endif

        // Mixed traffic.
        for (int i = 0; i < 24; i++) begin
            step(1'($urandom_range(0, 1)), 10'($urandom), 32'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), 1'b0);
        end
        step(0, 10'd0, 32'h0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
